// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour vote stage: candidate word
// layout, the invalid-label marker, FSM states and default sizing.
package knn_pkg;

  localparam int DIST_MSB  = 31;
  localparam int DIST_LSB  = 16;
  localparam int LABEL_MSB = 15;
  localparam int LABEL_LSB = 12;

  localparam logic [3:0] INVALID_LABEL = 4'hF;

  localparam int K_CONST_DEF  = 3;
  localparam int NUM_CAND_DEF = 6;

  typedef enum logic [1:0] {
    COLLECT,
    COUNT,
    SELECT,
    EMIT
  } state_e;

endpackage

// File: rtl/knn_topk_insert.sv
// K-deep sorted (distance, label) register file with single-cycle stable
// insertion; slot 0 holds the nearest entry.
module knn_topk_insert
  import knn_pkg::*;
#(
  parameter int K_CONST    = K_CONST_DEF,
  parameter int DIST_BITS  = 16,
  parameter int LABEL_BITS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [DIST_BITS-1:0]  dist_i,
  input  logic [LABEL_BITS-1:0] label_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [LABEL_BITS-1:0] rd_label_o
);

  logic [DIST_BITS-1:0]  dist_q  [K_CONST];
  logic [DIST_BITS-1:0]  dist_d  [K_CONST];
  logic [LABEL_BITS-1:0] label_q [K_CONST];
  logic [LABEL_BITS-1:0] label_d [K_CONST];
  logic [K_CONST-1:0]    gt;

  // Strict compare keeps equal distances in arrival order; slots stay sorted,
  // so gt is a thermometer code marking where the new entry lands.
  always_comb begin
    for (int i = 0; i < K_CONST; i++) begin
      gt[i] = dist_q[i] > dist_i;
    end
  end

  always_comb begin
    for (int i = 0; i < K_CONST; i++) begin
      dist_d[i]  = dist_q[i];
      label_d[i] = label_q[i];
    end
    if (clear_i) begin
      for (int i = 0; i < K_CONST; i++) begin
        dist_d[i]  = '1;
        label_d[i] = '1;
      end
    end else if (load_i) begin
      if (gt[0]) begin
        dist_d[0]  = dist_i;
        label_d[0] = label_i;
      end
      for (int i = 1; i < K_CONST; i++) begin
        if (gt[i]) begin
          if (gt[i-1]) begin
            dist_d[i]  = dist_q[i-1];
            label_d[i] = label_q[i-1];
          end else begin
            dist_d[i]  = dist_i;
            label_d[i] = label_i;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < K_CONST; i++) begin
        dist_q[i]  <= '1;
        label_q[i] <= '1;
      end
    end else begin
      dist_q  <= dist_d;
      label_q <= label_d;
    end
  end

  assign rd_label_o = label_q[rd_idx_i];

endmodule

// File: rtl/knn_vote_merge.sv
// Collects NUM_CAND candidate words per test digit, keeps the K nearest,
// majority-votes their labels and streams out one predicted-label word.
module knn_vote_merge
  import knn_pkg::*;
#(
  parameter int NUM_CAND   = NUM_CAND_DEF,
  parameter int K_CONST    = K_CONST_DEF,
  parameter int DIST_BITS  = 16,
  parameter int LABEL_BITS = 4,
  parameter int NUM_LABELS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Input_1_V_TDATA,
  input  logic        Input_1_V_TVALID,
  output logic        Input_1_V_TREADY,
  output logic [31:0] Output_1_V_TDATA,
  output logic        Output_1_V_TVALID,
  input  logic        Output_1_V_TREADY
);

  localparam int CC_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int IDX_W  = (K_CONST > 1) ? $clog2(K_CONST) : 1;
  localparam int VOTE_W = $clog2(K_CONST + 1);
  localparam logic [LABEL_BITS-1:0] NO_LABEL = '1;

  state_e                state_q, state_d;
  logic [CC_W-1:0]       cand_cnt_q, cand_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VOTE_W-1:0]     vote_q [NUM_LABELS];
  logic [VOTE_W-1:0]     vote_d [NUM_LABELS];
  logic [LABEL_BITS-1:0] best_label_q, best_label_d;
  logic [VOTE_W-1:0]     best_cnt_q, best_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_data_q, out_data_d;

  logic                  accept;
  logic                  out_fire;
  logic                  slot_clear;
  logic                  lbl_valid;
  logic [LABEL_BITS-1:0] slot_label;
  logic                  unused_low_bits;

  assign accept     = Input_1_V_TVALID & in_ready_q & (state_q == COLLECT);
  assign out_fire   = out_valid_q & Output_1_V_TREADY;
  assign slot_clear = (state_q == EMIT) & out_fire;
  assign lbl_valid  = slot_label < LABEL_BITS'(NUM_LABELS);
  assign unused_low_bits = ^Input_1_V_TDATA[LABEL_LSB-1:0];

  knn_topk_insert #(
    .K_CONST    (K_CONST),
    .DIST_BITS  (DIST_BITS),
    .LABEL_BITS (LABEL_BITS),
    .IDX_W      (IDX_W)
  ) u_topk (
    .clk_i      (clk),
    .rst_i      (reset),
    .clear_i    (slot_clear),
    .load_i     (accept),
    .dist_i     (Input_1_V_TDATA[DIST_MSB:DIST_LSB]),
    .label_i    (Input_1_V_TDATA[LABEL_MSB:LABEL_LSB]),
    .rd_idx_i   (idx_q),
    .rd_label_o (slot_label)
  );

  always_comb begin
    state_d      = state_q;
    cand_cnt_d   = cand_cnt_q;
    idx_d        = idx_q;
    vote_d       = vote_q;
    best_label_d = best_label_q;
    best_cnt_d   = best_cnt_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    unique case (state_q)
      COLLECT: begin
        in_ready_d = 1'b1;
        if (accept) begin
          if (cand_cnt_q == CC_W'(NUM_CAND - 1)) begin
            cand_cnt_d = '0;
            idx_d      = '0;
            in_ready_d = 1'b0;
            state_d    = COUNT;
            for (int l = 0; l < NUM_LABELS; l++) begin
              vote_d[l] = '0;
            end
          end else begin
            cand_cnt_d = cand_cnt_q + CC_W'(1);
          end
        end
      end
      COUNT: begin
        if (lbl_valid) begin
          vote_d[slot_label] = vote_q[slot_label] + VOTE_W'(1);
        end
        if (idx_q == IDX_W'(K_CONST - 1)) begin
          idx_d        = '0;
          best_label_d = NO_LABEL;
          best_cnt_d   = '0;
          state_d      = SELECT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SELECT: begin
        // Strict compare: on a tie the label seen at the lower slot wins.
        if (lbl_valid && (vote_q[slot_label] > best_cnt_q)) begin
          best_label_d = slot_label;
          best_cnt_d   = vote_q[slot_label];
        end
        if (idx_q == IDX_W'(K_CONST - 1)) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = {{(32 - LABEL_BITS){1'b0}}, best_label_d};
          state_d     = EMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      EMIT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      cand_cnt_q   <= '0;
      idx_q        <= '0;
      best_label_q <= NO_LABEL;
      best_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      for (int l = 0; l < NUM_LABELS; l++) begin
        vote_q[l] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cand_cnt_q   <= cand_cnt_d;
      idx_q        <= idx_d;
      best_label_q <= best_label_d;
      best_cnt_q   <= best_cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      vote_q       <= vote_d;
    end
  end

  assign Input_1_V_TREADY  = in_ready_q;
  assign Output_1_V_TVALID = out_valid_q;
  assign Output_1_V_TDATA  = out_data_q;

endmodule

// File: tb/tb_knn_vote_merge.sv
// Randomised and directed bench for knn_vote_merge against a sorted-list
// reference model of the nearest-neighbour vote.
module tb_knn_vote_merge;

  localparam int NC  = 6;
  localparam int K   = 3;
  localparam int LAT = 2 * K + 1;

  typedef logic [31:0] sample_t [NC];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  knn_vote_merge dut (
    .clk               (clk),
    .reset             (reset),
    .Input_1_V_TDATA   (in_data),
    .Input_1_V_TVALID  (in_valid),
    .Input_1_V_TREADY  (in_ready),
    .Output_1_V_TDATA  (out_data),
    .Output_1_V_TVALID (out_valid),
    .Output_1_V_TREADY (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input int d, input int l);
    logic [15:0] dd;
    logic [3:0]  ll;
    logic [11:0] junk;
    dd   = 16'(d);
    ll   = 4'(l);
    junk = 12'($urandom);
    return {dd, ll, junk};
  endfunction

  // Reference: slots start as K (0xFFFF, invalid) entries; each word is placed
  // after every entry with distance <= its own, then the list is cut to K.
  function automatic logic [3:0] ref_vote(input sample_t s);
    logic [15:0] d[$];
    logic [3:0]  l[$];
    int          pos;
    int          cnt [16];
    int          mx;
    logic [3:0]  best;
    for (int i = 0; i < K; i++) begin
      d.push_back(16'hFFFF);
      l.push_back(4'hF);
    end
    for (int w = 0; w < NC; w++) begin
      pos = d.size();
      for (int j = 0; j < d.size(); j++) begin
        if (d[j] > s[w][31:16]) begin
          pos = j;
          break;
        end
      end
      d.insert(pos, s[w][31:16]);
      l.insert(pos, s[w][15:12]);
    end
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int i = 0; i < K; i++) if (l[i] < 10) cnt[l[i]]++;
    mx = 0;
    for (int v = 0; v < 10; v++) if (cnt[v] > mx) mx = cnt[v];
    best = 4'hF;
    if (mx > 0) begin
      for (int i = 0; i < K; i++) begin
        if (l[i] < 10 && cnt[l[i]] == mx) begin
          best = l[i];
          break;
        end
      end
    end
    return best;
  endfunction

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_word(input logic [31:0] w, input int gap_pct);
    int t;
    int g;
    g = 0;
    while (g < 4 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check_eq("input accept timeout", 32'(t), 32'd0);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_words(input sample_t s, input int first, input int num, input int gap_pct);
    for (int i = first; i < first + num; i++) send_word(s[i], gap_pct);
  endtask

  // Called at the negedge after the last transfer edge.
  task automatic get_result(input string tag, input logic [3:0] exp, input int bp);
    int          n;
    logic        ready_low;
    logic        stable;
    logic [31:0] held;
    n = 0;
    ready_low = 1'b1;
    while (!out_valid && n < 50) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
      n++;
    end
    check_eq({tag, " valid"}, 32'(out_valid), 32'd1);
    if (!out_valid) return;
    check_eq({tag, " latency"}, 32'(n + 1), 32'(LAT));
    check_eq({tag, " in_ready low while busy"}, 32'(ready_low), 32'd1);
    check_eq({tag, " data"}, out_data, {28'b0, exp});
    held   = out_data;
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) stable = 1'b0;
    end
    if (bp > 0) check_eq({tag, " hold under backpressure"}, 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, " valid drops after handshake"}, 32'(out_valid), 32'd0);
    check_eq({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_sample(input string tag, input sample_t s, input int gap_pct,
                            input int bp, input logic [3:0] exp);
    send_words(s, 0, NC, gap_pct);
    get_result(tag, exp, bp);
  endtask

  initial begin
    sample_t s;
    int      n;

    repeat (3) @(negedge clk);
    check_eq("reset in_ready", 32'(in_ready), 32'd0);
    check_eq("reset out_valid", 32'(out_valid), 32'd0);
    check_eq("reset out_data", out_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("in_ready after reset", 32'(in_ready), 32'd1);

    s = '{mkw(40, 7), mkw(10, 3), mkw(25, 7), mkw(10, 5), mkw(99, 1), mkw(30, 3)};
    run_sample("mixed", s, 0, 0, 4'h3);

    s = '{mkw(5, 2), mkw(8, 4), mkw(6, 4), mkw(50, 2), mkw(7, 2), mkw(9, 9)};
    run_sample("majority+bp", s, 0, 5, 4'h2);

    s = '{mkw(1, 12), mkw(2, 12), mkw(3, 12), mkw(4, 12), mkw(5, 12), mkw(6, 12)};
    run_sample("invalid labels", s, 0, 0, 4'hF);

    s = '{mkw(16'hFFFF, 4), mkw(16'hFFFF, 4), mkw(16'hFFFF, 4),
          mkw(16'hFFFF, 4), mkw(16'hFFFF, 4), mkw(16'hFFFF, 4)};
    run_sample("all max distance", s, 0, 0, 4'hF);

    s = '{mkw(16'hFFFF, 4), mkw(16'hFFFF, 4), mkw(3, 6),
          mkw(16'hFFFF, 4), mkw(16'hFFFF, 4), mkw(16'hFFFF, 4)};
    run_sample("single near", s, 0, 0, 4'h6);

    s = '{mkw(1, 8), mkw(1, 8), mkw(1, 8), mkw(0, 1), mkw(0, 1), mkw(0, 1)};
    send_words(s, 0, 3, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("in_ready during mid reset", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("in_ready after mid reset", 32'(in_ready), 32'd1);
    s = '{mkw(5, 2), mkw(8, 4), mkw(6, 4), mkw(50, 2), mkw(7, 2), mkw(9, 9)};
    run_sample("after mid reset", s, 0, 0, 4'h2);

    s = '{mkw(3, 5), mkw(4, 5), mkw(9, 1), mkw(8, 1), mkw(2, 0), mkw(7, 7)};
    send_words(s, 0, NC, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("emit before reset", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("valid dropped by reset", 32'(out_valid), 32'd0);
    check_eq("data cleared by reset", out_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("in_ready after emit reset", 32'(in_ready), 32'd1);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NC; i++) begin
        int d;
        int l;
        d = ($urandom_range(99) < 10) ? 16'hFFFF : int'($urandom_range(40));
        l = ($urandom_range(99) < 85) ? int'($urandom_range(9)) : int'($urandom_range(15, 10));
        s[i] = mkw(d, l);
      end
      run_sample($sformatf("random %0d", r), s, 30, int'($urandom_range(3)), ref_vote(s));
    end

    $display("%0d/%0d checks passed", checks - errors, checks);
    $finish;
  end

endmodule
